// File: rtl/debounce_edge.sv
// debounce_edge: two-flop synchroniser, consecutive-sample debouncer (4-state FSM)
// and registered clean level with single-cycle rise/fall pulses.
module debounce_edge #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic D_in,
    output logic Q_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sync1, sync2;
    // Decision stage: level/pulses as decided by the FSM on the accepting edge.
    logic             q_dec, rise_dec, fall_dec;
    logic             q_nxt, rise_nxt, fall_nxt;

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= D_in;
            sync2 <= sync1;
        end
    end

    // FSM state, counter and decision-stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOW;
            cnt      <= '0;
            q_dec    <= 1'b0;
            rise_dec <= 1'b0;
            fall_dec <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            q_dec    <= q_nxt;
            rise_dec <= rise_nxt;
            fall_dec <= fall_nxt;
        end
    end

    // Next-state logic: count consecutive samples of the candidate level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q_dec;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            LOW: begin
                q_nxt = 1'b0;
                if (sync2) begin
                    state_nxt = CHK_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            CHK_HIGH: begin
                q_nxt = 1'b0;
                if (!sync2) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    q_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                q_nxt = 1'b1;
                if (!sync2) begin
                    state_nxt = CHK_LOW;
                    cnt_nxt   = CNT_ONE;
                end
            end
            CHK_LOW: begin
                q_nxt = 1'b1;
                if (sync2) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    q_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
                q_nxt     = 1'b0;
            end
        endcase
    end

    // Output register: drives the downstream flop bank from a dedicated flop,
    // landing the level and pulse at edge DB_CYCLES+2 after the input settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q_clean <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            Q_clean <= q_dec;
            rise    <= rise_dec;
            fall    <= fall_dec;
        end
    end

    // busy is a pure decode of the counting states.
    assign busy = (state == CHK_HIGH) || (state == CHK_LOW);

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: table-driven vectors plus directed multi-cycle sequences.
module tb_debounce_edge;

    logic clk, rst_n, D_in;
    logic Q_clean, rise, fall, busy;

    debounce_edge #(.DB_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .D_in(D_in),
        .Q_clean(Q_clean), .rise(rise), .fall(fall), .busy(busy)
    );

    typedef struct {
        logic d;
        logic q;
        logic r;
        logic f;
        logic b;
    } vec_t;

    vec_t tbl [26];
    int   npass = 0;
    int   ntot  = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    logic prev_pulse = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s @%0t: got {q,r,f,b}=%b expected %b", name, $time, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    task automatic setv(input int i, input logic d, input logic q, input logic r,
                        input logic f, input logic b);
        tbl[i] = '{d, q, r, f, b};
    endtask

    // Pulse monitor: counts pulses, flags overlapping or back-to-back pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rise) rise_cnt++;
            if (fall) fall_cnt++;
            chk("pulse_excl", {1'b0, rise && fall, prev_pulse && (rise || fall), 1'b0}, 4'b0000);
            prev_pulse = rise || fall;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        int rs, fs;
        // Rows: D_in driven before edge i, outputs expected just after edge i.
        // Rise: edges 0..8
        setv(0, 1, 0, 0, 0, 0); setv(1, 1, 0, 0, 0, 0); setv(2, 1, 0, 0, 0, 1);
        setv(3, 1, 0, 0, 0, 1); setv(4, 1, 0, 0, 0, 1); setv(5, 1, 0, 0, 0, 0);
        setv(6, 1, 1, 1, 0, 0); setv(7, 1, 1, 0, 0, 0); setv(8, 1, 1, 0, 0, 0);
        // Two-cycle low glitch: edges 9..16
        setv(9, 0, 1, 0, 0, 0);  setv(10, 0, 1, 0, 0, 0); setv(11, 1, 1, 0, 0, 1);
        setv(12, 1, 1, 0, 0, 1); setv(13, 1, 1, 0, 0, 0); setv(14, 1, 1, 0, 0, 0);
        setv(15, 1, 1, 0, 0, 0); setv(16, 1, 1, 0, 0, 0);
        // Fall: edges 17..25 (relative 0..8)
        setv(17, 0, 1, 0, 0, 0); setv(18, 0, 1, 0, 0, 0); setv(19, 0, 1, 0, 0, 1);
        setv(20, 0, 1, 0, 0, 1); setv(21, 0, 1, 0, 0, 1); setv(22, 0, 1, 0, 0, 0);
        setv(23, 0, 0, 0, 1, 0); setv(24, 0, 0, 0, 0, 0); setv(25, 0, 0, 0, 0, 0);

        // Reset
        rst_n = 1'b1; D_in = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("reset", {Q_clean, rise, fall, busy}, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle low for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("idle_low", {Q_clean, rise, fall, busy}, 4'b0000);
        end

        // Table: rise, glitch, fall
        rs = rise_cnt; fs = fall_cnt;
        for (int i = 0; i < 26; i++) begin
            if (i == 17) begin
                chk_int("rise_count_up", rise_cnt - rs, 1);
                chk_int("fall_count_glitch", fall_cnt - fs, 0);
                rs = rise_cnt; fs = fall_cnt;
            end
            D_in = tbl[i].d;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), {Q_clean, rise, fall, busy},
                {tbl[i].q, tbl[i].r, tbl[i].f, tbl[i].b});
        end
        chk_int("fall_count_down", fall_cnt - fs, 1);
        chk_int("rise_count_down", rise_cnt - rs, 0);

        // Async reset mid-count with D_in held high
        D_in = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("busy_midcount", {Q_clean, rise, fall, busy}, 4'b0001);
        rst_n = 1'b0;
        #1 chk("async_rst", {Q_clean, rise, fall, busy}, 4'b0000);
        repeat (2) @(posedge clk);
        #1 chk("rst_hold", {Q_clean, rise, fall, busy}, 4'b0000);
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_rel%0d", k), {Q_clean, rise, fall, busy},
                {k >= 6, k == 6, 1'b0, k >= 2 && k <= 4});
        end

        // Toggle every cycle, then hold high
        rst_n = 1'b0; D_in = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rs = rise_cnt; fs = fall_cnt;
        for (int i = 0; i < 50; i++) begin
            D_in = (i % 2 == 0);
            @(posedge clk); #1;
            chk("toggle", {Q_clean, rise, fall, 1'b0}, 4'b0000);
        end
        chk_int("toggle_pulses", (rise_cnt - rs) + (fall_cnt - fs), 0);
        D_in = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d", k), {Q_clean, rise, fall, 1'b0},
                {k >= 6, k == 6, 1'b0, 1'b0});
        end
        chk_int("hold_rise_count", rise_cnt - rs, 1);
        chk_int("hold_fall_count", fall_cnt - fs, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
